// File: rtl/mar_pkg.sv
// Shared definitions for the address burst register: state encoding and default widths.
package mar_pkg;

    typedef enum logic {
        MAR_IDLE = 1'b0,
        MAR_RUN  = 1'b1
    } mar_state_t;

    localparam int unsigned MAR_ADDR_W    = 4;
    localparam int unsigned MAR_STEP      = 1;
    localparam int unsigned MAR_MAX_BURST = 16;

endpackage : mar_pkg

// File: rtl/address_burst_register_burst_counter.sv
// Loadable down-counter with enable, clear and a registered zero flag.
// Tracks the beats remaining in a burst for address_burst_register.
module burst_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         resetbar,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         clear,
    output logic         zero
);

    logic [W-1:0] count;

    // Count register; zero flag is updated in step so it is glitch-free.
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (clear) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (en && !zero) begin
            count <= count - W'(1);
            zero  <= (count == W'(1));
        end
    end

endmodule : burst_counter

// File: rtl/address_burst_register.sv
// Parametrised memory address register with active-low parallel load and a
// self-stepping burst mode. Optional feature macro: MAR_AUTORESTORE_EN
// (when defined, address_out returns to the burst start address on completion).
module address_burst_register
    import mar_pkg::*;
#(
    parameter  int unsigned ADDR_W    = MAR_ADDR_W,
    parameter  int unsigned STEP      = MAR_STEP,
    parameter  int unsigned MAX_BURST = MAR_MAX_BURST,
    localparam int unsigned BURST_W   = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               resetbar,
    input  logic               loadbar,
    input  logic [ADDR_W-1:0]  address_in,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               hold,
    output logic [ADDR_W-1:0]  address_out,
    output logic               busy,
    output logic               last,
    output logic               done,
    output logic               wrap
);

    mar_state_t         state_q;
    mar_state_t         state_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               wrap_d;
    logic               done_d;
    logic               cnt_load;
    logic               cnt_en;
    logic               cnt_clear;
    logic               cnt_zero;
    logic [BURST_W-1:0] len_clamped;
    logic [BURST_W-1:0] cnt_load_val;
    logic [ADDR_W:0]    sum;

`ifdef MAR_AUTORESTORE_EN
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  base_d;
`endif

    // Burst length is clamped to MAX_BURST; the counter holds beats remaining after beat 0.
    assign len_clamped  = (burst_len > BURST_W'(MAX_BURST)) ? BURST_W'(MAX_BURST) : burst_len;
    assign cnt_load_val = len_clamped - BURST_W'(1);

    // Next address with carry out of the top bit for wrap detection.
    assign sum = {1'b0, address_out} + (ADDR_W + 1)'(STEP);

    // Final beat: in a burst with no beats left.
    assign last = busy && cnt_zero;

    // Beats-remaining counter.
    burst_counter #(
        .W (BURST_W)
    ) u_burst_counter (
        .clk      (clk),
        .resetbar (resetbar),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .clear    (cnt_clear),
        .zero     (cnt_zero)
    );

    // Next-state, next-address and flag logic; load outranks all other activity.
    always_comb begin
        state_d   = state_q;
        addr_d    = address_out;
        wrap_d    = wrap;
        done_d    = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_clear = 1'b0;
`ifdef MAR_AUTORESTORE_EN
        base_d    = base_q;
`endif
        case (state_q)
            MAR_IDLE: begin
                if (!loadbar) begin
                    addr_d = address_in;
                    wrap_d = 1'b0;
                end else if (start && (burst_len != '0)) begin
                    state_d  = MAR_RUN;
                    cnt_load = 1'b1;
                    wrap_d   = 1'b0;
`ifdef MAR_AUTORESTORE_EN
                    base_d   = address_out;
`endif
                end
            end
            MAR_RUN: begin
                if (!loadbar) begin
                    state_d   = MAR_IDLE;
                    addr_d    = address_in;
                    wrap_d    = 1'b0;
                    cnt_clear = 1'b1;
                end else if (hold) begin
                    state_d = MAR_RUN;
                end else if (!cnt_zero) begin
                    addr_d = sum[ADDR_W-1:0];
                    cnt_en = 1'b1;
                    if (sum[ADDR_W]) begin
                        wrap_d = 1'b1;
                    end
                end else begin
                    state_d = MAR_IDLE;
                    done_d  = 1'b1;
`ifdef MAR_AUTORESTORE_EN
                    addr_d  = base_q;
`endif
                end
            end
            default: begin
                state_d = MAR_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            state_q     <= MAR_IDLE;
            address_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_out <= addr_d;
            busy        <= (state_d == MAR_RUN);
            done        <= done_d;
            wrap        <= wrap_d;
        end
    end

`ifdef MAR_AUTORESTORE_EN
    // Burst start address, restored on normal completion.
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end
`endif

endmodule : address_burst_register
